// File: rtl/alu_serial_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// Master issues a full-width op; slave returns result and flags.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output start, src1, src2, ctrl,
    input  busy, done, result, zero, cout, overflow
  );

  modport slave (
    input  start, src1, src2, ctrl,
    output busy, done, result, zero, cout, overflow
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Drives one external 1-bit ALU slice LSB first, chaining its carry,
// and assembles a full-width result with zero/cout/overflow flags.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_serial_seq_if.slave   req,
  output logic              slice_src1_o,
  output logic              slice_src2_o,
  output logic              slice_less_o,
  output logic              slice_ainv_o,
  output logic              slice_binv_o,
  output logic              slice_cin_o,
  output logic [1:0]        slice_op_o,
  input  logic              slice_result_i,
  input  logic              slice_cout_i
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] sh_q;
  logic             ainv_q;
  logic             binv_q;
  logic [1:0]       op_q;
  logic             slt_q;
  logic             ovf_en_q;
  logic             cout_en_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic             d_ainv;
  logic             d_binv;
  logic [1:0]       d_op;
  logic             d_slt;
  logic             d_ovf_en;
  logic             d_cout_en;

  always_comb begin
    d_ainv    = 1'b0;
    d_binv    = 1'b0;
    d_op      = 2'b00;
    d_slt     = 1'b0;
    d_ovf_en  = 1'b0;
    d_cout_en = 1'b0;
    unique case (1'b1)
      (req.ctrl == 4'b0001): d_op = 2'b01;
      (req.ctrl == 4'b0010): begin
        d_op      = 2'b10;
        d_ovf_en  = 1'b1;
        d_cout_en = 1'b1;
      end
      (req.ctrl == 4'b0110): begin
        d_binv    = 1'b1;
        d_op      = 2'b10;
        d_ovf_en  = 1'b1;
        d_cout_en = 1'b1;
      end
      (req.ctrl == 4'b0111): begin
        d_binv    = 1'b1;
        d_op      = 2'b10;
        d_slt     = 1'b1;
        d_cout_en = 1'b1;
      end
      (req.ctrl == 4'b1100): begin
        d_ainv = 1'b1;
        d_binv = 1'b1;
      end
      default: ;
    endcase
  end

  logic             run;
  logic             last;
  logic             cin;
  logic             ovf_bit;
  logic             slt_bit;
  logic [WIDTH-1:0] sh_nx;
  logic [WIDTH-1:0] final_res;

  assign run  = (state == S_RUN);
  assign last = run && (idx == LAST);
  assign cin  = (idx == '0) ? binv_q : carry_q;

  // sh_nx is the assembled word once the MSB arrives
  assign sh_nx     = {slice_result_i, sh_q};
  assign ovf_bit   = cin ^ slice_cout_i;
  assign slt_bit   = slice_result_i ^ ovf_bit;
  assign final_res = slt_q ? {{(WIDTH-1){1'b0}}, slt_bit} : sh_nx;

  assign slice_src1_o = run & a_q[0];
  assign slice_src2_o = run & b_q[0];
  assign slice_less_o = 1'b0;
  assign slice_ainv_o = run & ainv_q;
  assign slice_binv_o = run & binv_q;
  assign slice_cin_o  = run & cin;
  assign slice_op_o   = run ? op_q : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      ainv_q    <= 1'b0;
      binv_q    <= 1'b0;
      op_q      <= 2'b00;
      slt_q     <= 1'b0;
      ovf_en_q  <= 1'b0;
      cout_en_q <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req.start) begin
            state     <= S_RUN;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= req.src1;
            b_q       <= req.src2;
            ainv_q    <= d_ainv;
            binv_q    <= d_binv;
            op_q      <= d_op;
            slt_q     <= d_slt;
            ovf_en_q  <= d_ovf_en;
            cout_en_q <= d_cout_en;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sh_q    <= sh_nx[WIDTH-1:1];
          carry_q <= slice_cout_i;
          idx     <= idx + 1'b1;
          if (last) begin
            state  <= S_DONE;
            idx    <= '0;
            res_q  <= final_res;
            zero_q <= ~|final_res;
            cout_q <= cout_en_q & slice_cout_i;
            ovf_q  <= ovf_en_q & ovf_bit;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          carry_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req.busy     = (state == S_RUN) || (state == S_DONE);
  assign req.done     = (state == S_DONE);
  assign req.result   = res_q;
  assign req.zero     = zero_q;
  assign req.cout     = cout_q;
  assign req.overflow = ovf_q;

endmodule
